mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single-port program/data memory between two requesters: the CPU control path (fetch, rd, wr, branch-target reads) and a DMA/program-loader port.
- Arbitrates requests round-robin, latches the winning request, and sequences the memory enables for a configurable access latency.
- Returns read data with a one-cycle ack.
- Supports bounded locked bursts, so a requester can complete multi-byte instructions without interleaving.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
MEM_LAT, 1, cycles mem_rd_en/mem_wr_en are held per access (legal range 1..15)
MAX_HOLD, 4, maximum consecutive locked accesses by one owner before forced re-arbitration (legal range 1..15)

Ports:
in_clk  input  1  clock; all logic on rising edge
in_rst  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
cpu_req  input  1  CPU access request
cpu_we  input  1  1 = write, 0 = read
cpu_lock  input  1  request to keep ownership for the next access
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_gnt  output  1  CPU owns the memory bus
cpu_ack  output  1  one-cycle pulse: access complete
dma_req, dma_we, dma_lock, dma_addr, dma_wdata  input  same widths  DMA-port equivalents
dma_gnt, dma_ack  output  1  DMA-port equivalents
rdata  output  DATA_W  read data; valid in the ack cycle, held until the next read completes
mem_addr  output  ADDR_W  to memory
mem_wdata  output  DATA_W  to memory
mem_rd_en  output  1  memory read enable
mem_wr_en  output  1  memory write enable
mem_rdata  input  DATA_W  from memory
busy  output  1  FSM not in IDLE
owner  output  1  0 = CPU, 1 = DMA; last or current owner

Behaviour:
- Reset (in_rst low at a clock edge), also mid-access:
  - state = IDLE.
  - All gnt/ack/mem enables = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - hold_cnt = 0, lat_cnt = 0.
  - last_owner = DMA, so the CPU wins the first tie.
  - owner = 1.
  - An in-flight access is abandoned; no ack is issued.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one requester asserts req: it wins.
  - Both assert req: the requester that is not last_owner wins.
  - On the edge: latch addr, we and wdata of the winner into mem_addr/mem_wdata/we_r; set owner and last_owner; hold_cnt = 1; lat_cnt = MEM_LAT-1; go to ACCESS.
- ACCESS:
  - Owner's gnt = 1.
  - mem_rd_en = ~we_r, mem_wr_en = we_r; held high for exactly MEM_LAT cycles.
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0: for a read, capture mem_rdata into rdata; go to ACK.
- ACK:
  - Owner's ack = 1 for one cycle; gnt stays 1; mem enables = 0.
  - Writes leave rdata unchanged.
  - If owner's req = 1, owner's lock = 1 and hold_cnt < MAX_HOLD: latch the owner's new addr/we/wdata (presented in this cycle), hold_cnt++, lat_cnt = MEM_LAT-1, go to ACCESS. No arbitration; the other requester waits.
  - Otherwise go to IDLE, gnt drops, hold_cnt = 0.
- Latency, single unlocked read with request first seen in IDLE at cycle 0:
  - mem_rd_en in cycles 1..MEM_LAT.
  - ack in cycle MEM_LAT+1.
  - Earliest re-arbitration in cycle MEM_LAT+2.
- Requester rules:
  - Hold req and fields stable until gnt is seen.
  - Drop req in the cycle after ack unless another access is wanted.
  - A req still high in IDLE is treated as a new request.
- Fairness:
  - A lock refused because hold_cnt == MAX_HOLD returns to IDLE.
  - If both requesters then request, round-robin grants the other requester.
- The non-owner's gnt and ack are always 0. gnt is never high for both requesters.
- Request inputs are ignored outside IDLE and outside the ACK lock-chain check.

Test Plan:
- Reset, then CPU read addr 0x10 (MEM_LAT=1, mem holds 0x5A) -> mem_rd_en cycle 1 with mem_addr=0x10; cpu_ack and rdata=0x5A cycle 2; dma_gnt stays 0.
- DMA write addr 0x20 data 0xC3 with MEM_LAT=3 -> mem_wr_en high exactly 3 cycles with mem_addr=0x20, mem_wdata=0xC3; dma_ack cycle 4; rdata unchanged.
- Both request every access from reset -> grants alternate CPU, DMA, CPU, DMA; owner toggles; no cycle with both gnt high.
- CPU locked burst of 6 reads while DMA requests (MAX_HOLD=4) -> CPU gets 4 back-to-back accesses without returning to IDLE; DMA served next; CPU resumes after DMA ack.
- in_rst low during ACCESS of a read -> next cycle state IDLE, mem_rd_en=0, no cpu_ack, rdata=0, owner=1; a subsequent simultaneous request is granted to the CPU.
- dma_req held high continuously with no lock -> one access per MEM_LAT+2 cycles; IDLE is visited (busy=0) between accesses.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-port program/data memory between the CPU control path and
// a DMA/program-loader port. Requests are arbitrated round-robin. The winning
// request is latched, and the memory enables are sequenced for MEM_LAT cycles.
// Completion is signalled with a one-cycle ack. A requester may chain up to
// MAX_HOLD accesses by holding its lock, so multi-byte instructions are not
// interleaved with the other port.
//
// Handshake: a requester raises req with stable we/addr/wdata (and optional
// lock) and keeps them until it sees its gnt. The access is complete in the
// cycle its ack is high, and read data is valid on rdata in that cycle.
// To chain a locked access, present the next req/lock/we/addr/wdata during
// the ack cycle. Otherwise drop req after ack. A req still high when the
// arbiter is idle is taken as a fresh request.
//
// Ports
//   in_clk, in_rst          clock, synchronous active-low reset
//   cpu_req/we/lock/addr/wdata  CPU request
//   cpu_gnt, cpu_ack        CPU owns bus / access complete pulse
//   dma_req/we/lock/addr/wdata  DMA request
//   dma_gnt, dma_ack        DMA owns bus / access complete pulse
//   rdata                   last read data (valid in ack cycle, then held)
//   mem_addr, mem_wdata     memory address / write data
//   mem_rd_en, mem_wr_en    memory enables, high for MEM_LAT cycles
//   mem_rdata               memory read data
//   busy                    arbiter is not idle
//   owner                   0 = CPU, 1 = DMA (current or last owner)
//   dbg_state               FSM state (0 idle, 1 access, 2 ack)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MEM_LAT  = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Latency counter reload: counts MEM_LAT-1 down to 0 while enables are high.
  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  logic [1:0]        r_state;
  // The current owner is also the last owner: it only changes on a grant, so
  // one register serves both the owner output and the round-robin pointer.
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [3:0]        r_hold_cnt;
  logic [3:0]        r_lat_cnt;

  logic              w_cpu_wins;
  logic              w_dma_wins;
  logic              w_grant;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_own_req;
  logic              w_own_lock;
  logic              w_own_we;
  logic [ADDR_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_wdata;
  logic              w_chain;
  logic              w_active;

  // Arbitration: a lone requester wins. On a tie, the CPU wins only if the
  // DMA went last, and the DMA wins otherwise.
  always_comb begin
    w_cpu_wins  = 1'b0;
    w_dma_wins  = 1'b0;
    w_grant     = 1'b0;
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    w_cpu_wins  = cpu_req & (~dma_req | (r_owner == OWN_DMA));
    w_dma_wins  = dma_req & ~w_cpu_wins;
    w_grant     = w_cpu_wins | w_dma_wins;
    if (w_dma_wins) begin
      w_win_we    = dma_we;
      w_win_addr  = dma_addr;
      w_win_wdata = dma_wdata;
    end else begin
      w_win_we    = cpu_we;
      w_win_addr  = cpu_addr;
      w_win_wdata = cpu_wdata;
    end
  end

  // Lock-chain check in the ack cycle. Only the owner's inputs are looked at,
  // so the other requester waits without being arbitrated.
  always_comb begin
    w_own_req   = 1'b0;
    w_own_lock  = 1'b0;
    w_own_we    = 1'b0;
    w_own_addr  = '0;
    w_own_wdata = '0;
    if (r_owner == OWN_DMA) begin
      w_own_req   = dma_req;
      w_own_lock  = dma_lock;
      w_own_we    = dma_we;
      w_own_addr  = dma_addr;
      w_own_wdata = dma_wdata;
    end else begin
      w_own_req   = cpu_req;
      w_own_lock  = cpu_lock;
      w_own_we    = cpu_we;
      w_own_addr  = cpu_addr;
      w_own_wdata = cpu_wdata;
    end
    w_chain = w_own_req & w_own_lock & (r_hold_cnt < HOLD_LIMIT);
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      // Any in-flight access is dropped without an ack.
      r_state     <= S_IDLE;
      r_owner     <= OWN_DMA;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_hold_cnt  <= 4'd0;
      r_lat_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state     <= S_ACCESS;
            r_owner     <= w_dma_wins;
            r_we        <= w_win_we;
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= w_win_wdata;
            r_hold_cnt  <= 4'd1;
            r_lat_cnt   <= LAT_LOAD;
          end
        end
        S_ACCESS: begin
          if (r_lat_cnt == 4'd0) begin
            if (!r_we) begin
              r_rdata <= mem_rdata;
            end
            r_state <= S_ACK;
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        S_ACK: begin
          if (w_chain) begin
            r_state     <= S_ACCESS;
            r_we        <= w_own_we;
            r_mem_addr  <= w_own_addr;
            r_mem_wdata <= w_own_wdata;
            r_hold_cnt  <= r_hold_cnt + 4'd1;
            r_lat_cnt   <= LAT_LOAD;
          end else begin
            r_state    <= S_IDLE;
            r_hold_cnt <= 4'd0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_active  = (r_state == S_ACCESS) | (r_state == S_ACK);

  assign cpu_gnt   = w_active & (r_owner == OWN_CPU);
  assign dma_gnt   = w_active & (r_owner == OWN_DMA);
  assign cpu_ack   = (r_state == S_ACK) & (r_owner == OWN_CPU);
  assign dma_ack   = (r_state == S_ACK) & (r_owner == OWN_DMA);
  assign mem_rd_en = (r_state == S_ACCESS) & ~r_we;
  assign mem_wr_en = (r_state == S_ACCESS) & r_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = r_rdata;
  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Two arbiters share the same requester inputs: index 0 has MEM_LAT=1 and
// index 1 has MEM_LAT=3, and both have MAX_HOLD=4. Each arbiter has its own
// behavioural memory.
//
// The reference model describes an access as a timeline. It counts the cycles
// since the grant: enables are high in cycles 1..L, and the ack comes in
// cycle L+1.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we, cpu_lock;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       dma_req, dma_we, dma_lock;
  logic [7:0] dma_addr, dma_wdata;

  logic [1:0] cpu_gnt_w, cpu_ack_w, dma_gnt_w, dma_ack_w;
  logic [1:0] rd_en_w, wr_en_w, busy_w, owner_w;
  logic [7:0] rdata_w     [2];
  logic [7:0] mem_addr_w  [2];
  logic [7:0] mem_wdata_w [2];
  logic [7:0] mem_rdata_w [2];
  logic [1:0] dbg_w       [2];

  logic [7:0] mem [2][256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .MAX_HOLD(MAX_HOLD)) u_dut_l1 (
    .in_clk(clk), .in_rst(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_w[0]), .cpu_ack(cpu_ack_w[0]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_w[0]), .dma_ack(dma_ack_w[0]),
    .rdata(rdata_w[0]), .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]),
    .mem_rd_en(rd_en_w[0]), .mem_wr_en(wr_en_w[0]), .mem_rdata(mem_rdata_w[0]),
    .busy(busy_w[0]), .owner(owner_w[0]), .dbg_state(dbg_w[0])
  );

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3), .MAX_HOLD(MAX_HOLD)) u_dut_l3 (
    .in_clk(clk), .in_rst(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_w[1]), .cpu_ack(cpu_ack_w[1]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_w[1]), .dma_ack(dma_ack_w[1]),
    .rdata(rdata_w[1]), .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]),
    .mem_rd_en(rd_en_w[1]), .mem_wr_en(wr_en_w[1]), .mem_rdata(mem_rdata_w[1]),
    .busy(busy_w[1]), .owner(owner_w[1]), .dbg_state(dbg_w[1])
  );

  // Behavioural memories: combinational read, write on each enabled edge.
  assign mem_rdata_w[0] = mem[0][mem_addr_w[0]];
  assign mem_rdata_w[1] = mem[1][mem_addr_w[1]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wr_en_w[k]) mem[k][mem_addr_w[k]] = mem_wdata_w[k];
    end
  end

  function automatic logic [7:0] init_val(logic [7:0] a);
    return (a == 8'h10) ? 8'h5A : (a ^ 8'hA5);
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // ---------------- reference model ----------------
  logic       m_active [2];
  logic       m_owner  [2];
  logic       m_we     [2];
  int         m_t      [2];
  int         m_hold   [2];
  logic [7:0] m_addr   [2];
  logic [7:0] m_wdata  [2];
  logic [7:0] m_rdata  [2];
  logic [7:0] m_mem    [2][256];

  always @(posedge clk) begin
    int   lat;
    logic pick_dma, own_req, own_lock;
    for (int k = 0; k < 2; k++) begin
      lat = lat_of(k);
      // The memory sees every write cycle, even one cut short by reset.
      if (m_active[k] && m_t[k] <= lat && m_we[k]) m_mem[k][m_addr[k]] = m_wdata[k];
      if (!rst_n) begin
        m_active[k] = 1'b0; m_owner[k] = 1'b1; m_we[k] = 1'b0;
        m_t[k] = 0; m_hold[k] = 0;
        m_addr[k] = 8'h00; m_wdata[k] = 8'h00; m_rdata[k] = 8'h00;
      end else if (!m_active[k]) begin
        if (cpu_req || dma_req) begin
          pick_dma    = dma_req && (!cpu_req || m_owner[k] == 1'b0);
          m_active[k] = 1'b1;
          m_owner[k]  = pick_dma;
          m_t[k]      = 1;
          m_hold[k]   = 1;
          m_we[k]     = pick_dma ? dma_we : cpu_we;
          m_addr[k]   = pick_dma ? dma_addr : cpu_addr;
          m_wdata[k]  = pick_dma ? dma_wdata : cpu_wdata;
        end
      end else if (m_t[k] <= lat) begin
        if (m_t[k] == lat && !m_we[k]) m_rdata[k] = m_mem[k][m_addr[k]];
        m_t[k] = m_t[k] + 1;
      end else begin
        own_req  = m_owner[k] ? dma_req : cpu_req;
        own_lock = m_owner[k] ? dma_lock : cpu_lock;
        if (own_req && own_lock && m_hold[k] < MAX_HOLD) begin
          m_we[k]    = m_owner[k] ? dma_we : cpu_we;
          m_addr[k]  = m_owner[k] ? dma_addr : cpu_addr;
          m_wdata[k] = m_owner[k] ? dma_wdata : cpu_wdata;
          m_hold[k]  = m_hold[k] + 1;
          m_t[k]     = 1;
        end else begin
          m_active[k] = 1'b0;
          m_hold[k]   = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 8'h00; dma_wdata = 8'h00;
  endtask

  // Leaves the bench one ns into cycle 0, the first cycle out of reset.
  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({cpu_gnt_w[k], dma_gnt_w[k], cpu_ack_w[k], dma_ack_w[k], rd_en_w[k], wr_en_w[k], busy_w[k]} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d]: got %b expected 0000000", k,
                 {cpu_gnt_w[k], dma_gnt_w[k], cpu_ack_w[k], dma_ack_w[k], rd_en_w[k], wr_en_w[k], busy_w[k]});
      end
      n_checks++;
      if (owner_w[k] !== 1'b1) begin
        n_fail++; $display("FAIL reset_owner[%0d]: got %b expected 1", k, owner_w[k]);
      end
      n_checks++;
      if ({rdata_w[k], mem_addr_w[k], mem_wdata_w[k]} !== 24'h0) begin
        n_fail++;
        $display("FAIL reset_data[%0d]: got %h %h %h expected 00 00 00", k, rdata_w[k], mem_addr_w[k], mem_wdata_w[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    step();                     // cycle 1
    cpu_req = 0;
    n_checks++;
    if ({rd_en_w[0], wr_en_w[0], cpu_gnt_w[0], dma_gnt_w[0]} !== 4'b1010 || mem_addr_w[0] !== 8'h10) begin
      n_fail++;
      $display("FAIL cpu_read_c1: got en/gnt %b addr %h expected 1010 addr 10",
               {rd_en_w[0], wr_en_w[0], cpu_gnt_w[0], dma_gnt_w[0]}, mem_addr_w[0]);
    end
    step();                     // cycle 2
    n_checks++;
    if ({cpu_ack_w[0], rd_en_w[0], dma_gnt_w[0]} !== 3'b100 || rdata_w[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL cpu_read_c2: got ack/rd/dgnt %b rdata %h expected 100 rdata 5a",
               {cpu_ack_w[0], rd_en_w[0], dma_gnt_w[0]}, rdata_w[0]);
    end
    step();                     // cycle 3
    n_checks++;
    if ({cpu_ack_w[0], busy_w[0], cpu_gnt_w[0]} !== 3'b000 || rdata_w[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL cpu_read_c3: got ack/busy/gnt %b rdata %h expected 000 rdata 5a",
               {cpu_ack_w[0], busy_w[0], cpu_gnt_w[0]}, rdata_w[0]);
    end
  endtask

  task automatic test_dma_write();
    apply_reset();
    dma_req = 1; dma_we = 1; dma_addr = 8'h20; dma_wdata = 8'hC3;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) dma_req = 0;
      n_checks++;
      if ({wr_en_w[1], rd_en_w[1], dma_ack_w[1], dma_gnt_w[1], cpu_gnt_w[1]} !==
          {1'(c <= 3), 1'b0, 1'(c == 4), 1'(c <= 4), 1'b0}) begin
        n_fail++;
        $display("FAIL dma_write_ctrl c%0d: got wr/rd/ack/gnt/cgnt %b expected %b", c,
                 {wr_en_w[1], rd_en_w[1], dma_ack_w[1], dma_gnt_w[1], cpu_gnt_w[1]},
                 {1'(c <= 3), 1'b0, 1'(c == 4), 1'(c <= 4), 1'b0});
      end
      if (c <= 3) begin
        n_checks++;
        if (mem_addr_w[1] !== 8'h20 || mem_wdata_w[1] !== 8'hC3) begin
          n_fail++;
          $display("FAIL dma_write_bus c%0d: got addr %h data %h expected 20 c3", c, mem_addr_w[1], mem_wdata_w[1]);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (rdata_w[1] !== 8'h00) begin
          n_fail++; $display("FAIL dma_write_rdata: got %h expected 00", rdata_w[1]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int p, lat, n;
    logic [1:0] exp_ack;
    apply_reset();
    cpu_req = 1; cpu_addr = 8'h11; dma_req = 1; dma_addr = 8'h22;
    for (int c = 1; c <= 24; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        lat = lat_of(k);
        p   = lat + 2;
        exp_ack = 2'b00;
        if ((c % p) == lat + 1) begin
          n = c / p;
          exp_ack = (n % 2 == 0) ? 2'b10 : 2'b01;
          n_checks++;
          if (owner_w[k] !== exp_ack[0]) begin
            n_fail++; $display("FAIL rr_owner[%0d] c%0d: got %b expected %b", k, c, owner_w[k], exp_ack[0]);
          end
        end
        n_checks++;
        if ({cpu_ack_w[k], dma_ack_w[k]} !== exp_ack) begin
          n_fail++;
          $display("FAIL rr_ack[%0d] c%0d: got %b expected %b", k, c, {cpu_ack_w[k], dma_ack_w[k]}, exp_ack);
        end
        n_checks++;
        if (cpu_gnt_w[k] && dma_gnt_w[k]) begin
          n_fail++; $display("FAIL rr_dual_gnt[%0d] c%0d: got 11 expected at most one", k, c);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_locked_burst();
    logic [17:0] exp_cack, exp_dack, exp_busy;
    int ack_idx;
    exp_cack = 18'b0; exp_dack = 18'b0; exp_busy = '1;
    exp_cack[2] = 1; exp_cack[4] = 1; exp_cack[6] = 1; exp_cack[8] = 1; exp_cack[14] = 1; exp_cack[16] = 1;
    exp_dack[11] = 1;
    exp_busy[0] = 0; exp_busy[9] = 0; exp_busy[12] = 0; exp_busy[17] = 0;
    ack_idx = 0;
    apply_reset();
    cpu_req = 1; cpu_lock = 1; cpu_we = 0; cpu_addr = 8'h30;
    dma_req = 1; dma_we = 0; dma_addr = 8'h40;
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) step();
      case (c)
        2: cpu_addr = 8'h31;
        4: cpu_addr = 8'h32;
        6: cpu_addr = 8'h33;
        8: cpu_addr = 8'h34;
        12: dma_req = 0;
        14: cpu_addr = 8'h35;
        16: cpu_lock = 0;
        17: cpu_req = 0;
        default: ;
      endcase
      n_checks++;
      if ({cpu_ack_w[0], dma_ack_w[0], busy_w[0]} !== {exp_cack[c], exp_dack[c], exp_busy[c]}) begin
        n_fail++;
        $display("FAIL burst_ctrl c%0d: got cack/dack/busy %b expected %b", c,
                 {cpu_ack_w[0], dma_ack_w[0], busy_w[0]}, {exp_cack[c], exp_dack[c], exp_busy[c]});
      end
      n_checks++;
      if (cpu_gnt_w[0] && dma_gnt_w[0]) begin
        n_fail++; $display("FAIL burst_dual_gnt c%0d: got 11 expected at most one", c);
      end
      if (exp_cack[c]) begin
        n_checks++;
        if (rdata_w[0] !== init_val(8'(8'h30 + ack_idx)) || mem_addr_w[0] !== 8'(8'h30 + ack_idx)) begin
          n_fail++;
          $display("FAIL burst_cpu_data c%0d: got addr %h rdata %h expected addr %h rdata %h", c,
                   mem_addr_w[0], rdata_w[0], 8'(8'h30 + ack_idx), init_val(8'(8'h30 + ack_idx)));
        end
        ack_idx++;
      end
      if (exp_dack[c]) begin
        n_checks++;
        if (rdata_w[0] !== init_val(8'h40)) begin
          n_fail++; $display("FAIL burst_dma_data: got %h expected %h", rdata_w[0], init_val(8'h40));
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    step();                     // cycle 1
    cpu_req = 0;
    n_checks++;
    if (rd_en_w[1] !== 1'b1) begin
      n_fail++; $display("FAIL midrst_rd_before: got %b expected 1", rd_en_w[1]);
    end
    step();                     // cycle 2, still reading
    rst_n = 1'b0;
    step();                     // cycle 3, reset taken
    rst_n = 1'b1;
    cpu_req = 1; dma_req = 1; dma_addr = 8'h50;
    n_checks++;
    if ({busy_w[1], rd_en_w[1], cpu_ack_w[1], cpu_gnt_w[1], owner_w[1]} !== 5'b00001 || rdata_w[1] !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_state: got busy/rd/ack/gnt/owner %b rdata %h expected 00001 rdata 00",
               {busy_w[1], rd_en_w[1], cpu_ack_w[1], cpu_gnt_w[1], owner_w[1]}, rdata_w[1]);
    end
    step();                     // cycle 4
    cpu_req = 0; dma_req = 0;
    n_checks++;
    if ({cpu_gnt_w[1], dma_gnt_w[1]} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_tie_gnt: got %b expected 10", {cpu_gnt_w[1], dma_gnt_w[1]});
    end
    for (int c = 5; c <= 7; c++) begin
      step();
      n_checks++;
      if (cpu_ack_w[1] !== 1'(c == 7)) begin
        n_fail++; $display("FAIL midrst_ack c%0d: got %b expected %b", c, cpu_ack_w[1], 1'(c == 7));
      end
    end
    n_checks++;
    if (rdata_w[1] !== 8'h5A) begin
      n_fail++; $display("FAIL midrst_rdata: got %h expected 5a", rdata_w[1]);
    end
  endtask

  task automatic test_dma_stream();
    int p, lat;
    apply_reset();
    dma_req = 1; dma_we = 0; dma_addr = 8'h60;
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) step();
      for (int k = 0; k < 2; k++) begin
        lat = lat_of(k);
        p   = lat + 2;
        n_checks++;
        if ({busy_w[k], dma_ack_w[k]} !== {1'((c % p) != 0), 1'((c % p) == lat + 1)}) begin
          n_fail++;
          $display("FAIL stream[%0d] c%0d: got busy/ack %b expected %b", k, c,
                   {busy_w[k], dma_ack_w[k]}, {1'((c % p) != 0), 1'((c % p) == lat + 1)});
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [7:0] exp_ctrl, got_ctrl;
    int lat;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if (c > 0) step();
      for (int k = 0; k < 2; k++) begin
        lat = lat_of(k);
        exp_ctrl = {m_active[k] && !m_owner[k], m_active[k] && m_owner[k],
                    m_active[k] && m_t[k] == lat + 1 && !m_owner[k],
                    m_active[k] && m_t[k] == lat + 1 && m_owner[k],
                    m_active[k] && m_t[k] <= lat && !m_we[k],
                    m_active[k] && m_t[k] <= lat && m_we[k],
                    m_active[k], m_owner[k]};
        got_ctrl = {cpu_gnt_w[k], dma_gnt_w[k], cpu_ack_w[k], dma_ack_w[k],
                    rd_en_w[k], wr_en_w[k], busy_w[k], owner_w[k]};
        n_checks++;
        if (got_ctrl !== exp_ctrl) begin
          n_fail++; $display("FAIL rand_ctrl[%0d] c%0d: got %b expected %b", k, c, got_ctrl, exp_ctrl);
        end
        n_checks++;
        if ({mem_addr_w[k], mem_wdata_w[k], rdata_w[k]} !== {m_addr[k], m_wdata[k], m_rdata[k]}) begin
          n_fail++;
          $display("FAIL rand_data[%0d] c%0d: got addr %h wdata %h rdata %h expected %h %h %h", k, c,
                   mem_addr_w[k], mem_wdata_w[k], rdata_w[k], m_addr[k], m_wdata[k], m_rdata[k]);
        end
      end
      rst_n     = ($urandom_range(0, 99) != 0);
      cpu_req   = ($urandom_range(0, 9) < 6);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_lock  = 1'($urandom_range(0, 1));
      cpu_addr  = 8'($urandom_range(0, 255));
      cpu_wdata = 8'($urandom_range(0, 255));
      dma_req   = ($urandom_range(0, 9) < 6);
      dma_we    = 1'($urandom_range(0, 1));
      dma_lock  = 1'($urandom_range(0, 1));
      dma_addr  = 8'($urandom_range(0, 255));
      dma_wdata = 8'($urandom_range(0, 255));
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) begin
        mem[k][i]   = init_val(8'(i));
        m_mem[k][i] = init_val(8'(i));
      end
    end
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_round_robin();
    test_locked_burst();
    test_reset_mid_access();
    test_dma_stream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
